// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte blocks.
// It answers the CPU memory stage and stalls the pipeline with BUSY_WAIT
// while a miss is serviced. Misses are serviced over a 128-bit block port
// to main memory, which signals completion by dropping MEM_BUSY_WAIT.
module data_cache_controller #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   READ_EN,
    input  logic [2:0]   WRITE_EN,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITE_DATA,
    output logic [31:0]  READ_DATA,
    output logic         BUSY_WAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITE_DATA,
    input  logic [127:0] MEM_READ_DATA,
    input  logic         MEM_BUSY_WAIT
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE
    } state_t;

    state_t state;
    state_t next_state;

    // Per-line storage. Only valid and dirty are cleared by reset; stale
    // tags and data are harmless once their valid bit is low.
    logic [LINES-1:0]    valid_bits;
    logic [LINES-1:0]    dirty_bits;
    logic [TAG_BITS-1:0] tag_array  [LINES];
    logic [127:0]        data_array [LINES];

    // The block being filled is latched when the miss is detected, so a
    // fill that outlives the CPU request still lands in the right line.
    logic [TAG_BITS-1:0]   miss_tag;
    logic [INDEX_BITS-1:0] miss_index;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [1:0]            word_sel;
    logic [1:0]            byte_sel;
    logic                  read_req;
    logic                  write_req;
    logic                  request;
    logic                  hit;
    logic [27:0]           fill_block;

    logic [127:0] sel_line;
    logic [31:0]  sel_word;
    logic [15:0]  sel_half;
    logic [7:0]   sel_byte;
    logic [31:0]  merged_word;
    logic [127:0] merged_line;

    assign req_tag   = ADDRESS[31:4+INDEX_BITS];
    assign req_index = ADDRESS[3+INDEX_BITS:4];
    assign word_sel  = ADDRESS[3:2];
    assign byte_sel  = ADDRESS[1:0];
    assign read_req  = READ_EN[3];
    assign write_req = WRITE_EN[2];
    assign request   = read_req | write_req;
    assign hit       = valid_bits[req_index] && (tag_array[req_index] == req_tag);

    // The fill address comes straight from the CPU on the miss edge and from
    // the latched copy once the miss is already in flight.
    assign fill_block = (state == IDLE) ? {req_tag, req_index} : {miss_tag, miss_index};

    // Stall while a miss is pending; the stall drops in the cycle the line
    // becomes a hit so the CPU advances on the following edge.
    assign BUSY_WAIT = RESET & request & ((state != IDLE) | ~hit);

    // Pick the addressed word, halfword and byte out of the indexed line.
    always_comb begin
        sel_line = data_array[req_index];
        sel_word = sel_line[{word_sel, 5'd0} +: 32];
        sel_byte = sel_word[{byte_sel, 3'd0} +: 8];
        sel_half = byte_sel[1] ? sel_word[31:16] : sel_word[15:0];
    end

    // Load result: only a load-only hit in IDLE returns data, extended by funct3.
    always_comb begin
        READ_DATA = 32'd0;
        if (RESET && (state == IDLE) && read_req && !write_req && hit) begin
            case (READ_EN[2:0])
                3'b000:  READ_DATA = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  READ_DATA = {{16{sel_half[15]}}, sel_half};
                3'b010:  READ_DATA = sel_word;
                3'b100:  READ_DATA = {24'd0, sel_byte};
                3'b101:  READ_DATA = {16'd0, sel_half};
                default: READ_DATA = 32'd0;
            endcase
        end
    end

    // Merge store data into the addressed word and then into the whole line.
    always_comb begin
        merged_word = sel_word;
        case (WRITE_EN[1:0])
            2'b00: merged_word[{byte_sel, 3'd0} +: 8] = WRITE_DATA[7:0];
            2'b01: begin
                if (byte_sel[1]) begin
                    merged_word[31:16] = WRITE_DATA[15:0];
                end else begin
                    merged_word[15:0] = WRITE_DATA[15:0];
                end
            end
            default: merged_word = WRITE_DATA;
        endcase
        merged_line = sel_line;
        merged_line[{word_sel, 5'd0} +: 32] = merged_word;
    end

    // Miss FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request && !hit) begin
                    if (valid_bits[req_index] && dirty_bits[req_index]) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (!MEM_BUSY_WAIT) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (!MEM_BUSY_WAIT) begin
                    next_state = UPDATE;
                end
            end
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory-side strobes follow the state they belong to; address and victim
    // data are loaded on entry to a transfer and held until the next one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            MEM_READ       <= 1'b0;
            MEM_WRITE      <= 1'b0;
            MEM_ADDRESS    <= 28'd0;
            MEM_WRITE_DATA <= 128'd0;
        end else begin
            MEM_READ  <= (next_state == ALLOCATE);
            MEM_WRITE <= (next_state == WRITEBACK);
            if ((state == IDLE) && (next_state == WRITEBACK)) begin
                MEM_ADDRESS    <= {tag_array[req_index], req_index};
                MEM_WRITE_DATA <= data_array[req_index];
            end else if ((state != ALLOCATE) && (next_state == ALLOCATE)) begin
                MEM_ADDRESS <= fill_block;
            end
        end
    end

    // Remember which block the current miss is fetching.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            miss_tag   <= '0;
            miss_index <= '0;
        end else if ((state == IDLE) && request && !hit) begin
            miss_tag   <= req_tag;
            miss_index <= req_index;
        end
    end

    // Valid and dirty bookkeeping: a fill makes a line clean, a store hit dirties it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (state == UPDATE) begin
            valid_bits[miss_index] <= 1'b1;
            dirty_bits[miss_index] <= 1'b0;
        end else if ((state == IDLE) && write_req && hit) begin
            dirty_bits[req_index] <= 1'b1;
        end
    end

    // Tag and data arrays: loaded by a fill, merged by a store hit.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data_array[miss_index] <= MEM_READ_DATA;
            tag_array[miss_index]  <= miss_tag;
        end else if ((state == IDLE) && write_req && hit) begin
            data_array[req_index] <= merged_line;
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller. A byte-addressed
// architectural memory predicts load results, a small tag/valid/dirty table
// predicts hit, miss and writeback behaviour, and a latency-programmable
// block memory sits on the memory port.
module tb_data_cache_controller;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [3:0]   READ_EN = 4'd0;
    logic [2:0]   WRITE_EN = 3'd0;
    logic [31:0]  ADDRESS = 32'd0;
    logic [31:0]  WRITE_DATA = 32'd0;
    logic [31:0]  READ_DATA;
    logic         BUSY_WAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITE_DATA;
    logic [127:0] mem_rdata;
    logic         mem_busy;

    data_cache_controller #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .READ_EN        (READ_EN),
        .WRITE_EN       (WRITE_EN),
        .ADDRESS        (ADDRESS),
        .WRITE_DATA     (WRITE_DATA),
        .READ_DATA      (READ_DATA),
        .BUSY_WAIT      (BUSY_WAIT),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDRESS    (MEM_ADDRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_READ_DATA  (mem_rdata),
        .MEM_BUSY_WAIT  (mem_busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Block memory: busy for mem_lat cycles after a request appears.
    int           mem_lat = 0;
    int           mem_cnt = 0;
    logic [127:0] mem_blocks  [256];
    logic [127:0] init_blocks [256];
    logic         mem_load_req = 1'b0;

    assign mem_busy  = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat);
    assign mem_rdata = mem_blocks[MEM_ADDRESS[7:0]];

    always @(posedge CLK) begin
        if (mem_load_req) begin
            for (int b = 0; b < 256; b++) mem_blocks[b] <= init_blocks[b];
        end else if (!mem_busy) begin
            mem_cnt <= 0;
            if (MEM_WRITE) mem_blocks[MEM_ADDRESS[7:0]] <= MEM_WRITE_DATA;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [4096];
    bit          ref_valid [8];
    bit          ref_dirty [8];
    logic [24:0] ref_tag [8];

    // Observations of the last access.
    int           obs_busy;
    int           obs_rd_cycles;
    int           obs_wr_cycles;
    logic [27:0]  obs_rd_addr;
    logic [27:0]  obs_wr_addr;
    logic [127:0] obs_wr_data;
    bit           obs_overlap;
    logic [31:0]  obs_rdata;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int b;
        int h;
        int w;
        logic [15:0] half;
        b = int'(a[11:0]);
        h = b & ~1;
        w = b & ~3;
        half = {ref_mem[h+1], ref_mem[h]};
        case (f3)
            3'b000:  return {{24{ref_mem[b][7]}}, ref_mem[b]};
            3'b100:  return {24'd0, ref_mem[b]};
            3'b001:  return {{16{half[15]}}, half};
            3'b101:  return {16'd0, half};
            3'b010:  return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] d);
        int b;
        b = int'(a[11:0]);
        case (f3)
            2'b00: ref_mem[b] = d[7:0];
            2'b01: begin
                ref_mem[b & ~1]       = d[7:0];
                ref_mem[(b & ~1) + 1] = d[15:8];
            end
            default: begin
                for (int i = 0; i < 4; i++) ref_mem[(b & ~3) + i] = d[i*8 +: 8];
            end
        endcase
    endtask

    function automatic logic [127:0] ref_block(input logic [27:0] blk);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = ref_mem[int'(blk[7:0])*16 + i];
        return v;
    endfunction

    task automatic sync_ref_from_mem();
        for (int b = 0; b < 256; b++) begin
            for (int i = 0; i < 16; i++) ref_mem[b*16 + i] = mem_blocks[b][i*8 +: 8];
        end
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    // Drive one request and hold it until the stall clears; records memory-side activity.
    task automatic access(input bit is_store, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        bit done;
        done = 1'b0;
        obs_busy = 0;
        obs_rd_cycles = 0;
        obs_wr_cycles = 0;
        obs_rd_addr = '1;
        obs_wr_addr = '1;
        obs_wr_data = '1;
        obs_overlap = 1'b0;
        obs_rdata = '1;
        ADDRESS = addr;
        WRITE_DATA = wdata;
        READ_EN = is_store ? 4'd0 : {1'b1, f3};
        WRITE_EN = is_store ? {1'b1, f3[1:0]} : 3'd0;
        while (!done) begin
            @(negedge CLK);
            if (MEM_READ && MEM_WRITE) obs_overlap = 1'b1;
            if (MEM_READ) begin
                if (obs_rd_cycles == 0) obs_rd_addr = MEM_ADDRESS;
                obs_rd_cycles++;
            end
            if (MEM_WRITE) begin
                if (obs_wr_cycles == 0) begin
                    obs_wr_addr = MEM_ADDRESS;
                    obs_wr_data = MEM_WRITE_DATA;
                end
                obs_wr_cycles++;
            end
            if (BUSY_WAIT === 1'b1) begin
                obs_busy++;
                if (obs_busy > 200) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL access_timeout: got %0d stall cycles, required under 200", obs_busy);
                    done = 1'b1;
                end
            end else begin
                obs_rdata = READ_DATA;
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        READ_EN = 4'd0;
        WRITE_EN = 3'd0;
    endtask

    // Access plus model-predicted checks of stalls, data and memory traffic.
    task automatic run_access(input bit is_store, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int           idx;
        logic [24:0]  tg;
        bit           hit;
        bit           dirty_victim;
        logic [27:0]  victim_addr;
        logic [127:0] victim_data;
        int           exp_busy;
        logic [31:0]  exp_rdata;
        idx = int'(addr[6:4]);
        tg = addr[31:7];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        dirty_victim = !hit && ref_valid[idx] && ref_dirty[idx];
        victim_addr = {ref_tag[idx], addr[6:4]};
        victim_data = ref_block(victim_addr);
        exp_busy = hit ? 0 : (1 + (dirty_victim ? mem_lat + 1 : 0) + mem_lat + 1 + 1);
        exp_rdata = ref_load(f3, addr);

        access(is_store, f3, addr, wdata);

        total++;
        if (obs_busy !== exp_busy) begin
            bad++;
            $display("[TB] FAIL stall_cycles @%h: got %0d required %0d", addr, obs_busy, exp_busy);
        end
        if (!is_store) begin
            total++;
            if (obs_rdata !== exp_rdata) begin
                bad++;
                $display("[TB] FAIL load_data f3=%0d @%h: got %h required %h", f3, addr, obs_rdata, exp_rdata);
            end
        end
        total++;
        if (obs_overlap !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_write_overlap @%h: got 1 required 0", addr);
        end
        if (!hit) begin
            total++;
            if (obs_rd_addr !== addr[31:4]) begin
                bad++;
                $display("[TB] FAIL fill_address @%h: got %h required %h", addr, obs_rd_addr, addr[31:4]);
            end
        end
        if (dirty_victim) begin
            total++;
            if (obs_wr_addr !== victim_addr || obs_wr_data !== victim_data) begin
                bad++;
                $display("[TB] FAIL writeback @%h: got %h/%h required %h/%h", addr, obs_wr_addr, obs_wr_data, victim_addr, victim_data);
            end
        end else begin
            total++;
            if (obs_wr_cycles !== 0) begin
                bad++;
                $display("[TB] FAIL spurious_writeback @%h: got %0d cycles required 0", addr, obs_wr_cycles);
            end
        end

        if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx] = tg;
            ref_dirty[idx] = 1'b0;
        end
        if (is_store) begin
            ref_dirty[idx] = 1'b1;
            ref_store(f3[1:0], addr, wdata);
        end
    endtask

    task automatic test_reset();
        READ_EN = 4'b1010;
        ADDRESS = 32'h40;
        for (int b = 0; b < 256; b++) init_blocks[b] = {$urandom, $urandom, $urandom, $urandom};
        init_blocks[4] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h8001_1111};
        mem_load_req = 1'b1;
        @(posedge CLK);
        #1;
        mem_load_req = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (BUSY_WAIT !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_wait: got %b required 0", BUSY_WAIT); end
        total++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes: got %b%b required 00", MEM_READ, MEM_WRITE); end
        total++;
        if (MEM_ADDRESS !== 28'd0 || MEM_WRITE_DATA !== 128'd0) begin bad++; $display("[TB] FAIL reset_mem_bus: got %h/%h required 0/0", MEM_ADDRESS, MEM_WRITE_DATA); end
        total++;
        if (READ_DATA !== 32'd0) begin bad++; $display("[TB] FAIL reset_read_data: got %h required 0", READ_DATA); end
        READ_EN = 4'd0;
        sync_ref_from_mem();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fill();
        mem_lat = 0;
        run_access(1'b0, 3'b010, 32'h40, 32'd0);
        total++;
        if (obs_busy !== 3 || obs_rd_cycles !== 1 || obs_rd_addr !== 28'h4) begin
            bad++;
            $display("[TB] FAIL first_fill: got busy=%0d rd=%0d addr=%h required 3/1/0000004", obs_busy, obs_rd_cycles, obs_rd_addr);
        end
        total++;
        if (obs_rdata !== 32'h8001_1111) begin bad++; $display("[TB] FAIL first_fill_data: got %h required 80011111", obs_rdata); end
    endtask

    task automatic test_extend();
        run_access(1'b0, 3'b000, 32'h43, 32'd0);
        total++;
        if (obs_rdata !== 32'hFFFF_FF80 || obs_busy !== 0) begin bad++; $display("[TB] FAIL lb_sign: got %h busy=%0d required ffffff80 busy=0", obs_rdata, obs_busy); end
        run_access(1'b0, 3'b100, 32'h43, 32'd0);
        total++;
        if (obs_rdata !== 32'h0000_0080) begin bad++; $display("[TB] FAIL lbu_zero: got %h required 00000080", obs_rdata); end
        run_access(1'b0, 3'b001, 32'h42, 32'd0);
        total++;
        if (obs_rdata !== 32'hFFFF_8001) begin bad++; $display("[TB] FAIL lh_sign: got %h required ffff8001", obs_rdata); end
    endtask

    task automatic test_store_hit();
        run_access(1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF);
        total++;
        if (obs_busy !== 0) begin bad++; $display("[TB] FAIL store_hit_stall: got %0d required 0", obs_busy); end
        run_access(1'b0, 3'b010, 32'h44, 32'd0);
        total++;
        if (obs_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL sw_readback: got %h required deadbeef", obs_rdata); end
        run_access(1'b1, 3'b000, 32'h45, 32'h12);
        run_access(1'b0, 3'b010, 32'h44, 32'd0);
        total++;
        if (obs_rdata !== 32'hDEAD_12EF) begin bad++; $display("[TB] FAIL sb_merge: got %h required dead12ef", obs_rdata); end
    endtask

    task automatic test_conflict();
        mem_lat = 5;
        run_access(1'b0, 3'b010, 32'hC0, 32'd0);
        total++;
        if (obs_wr_addr !== 28'h4 || obs_wr_data[63:32] !== 32'hDEAD_12EF) begin
            bad++;
            $display("[TB] FAIL conflict_writeback: got %h/%h required 0000004/dead12ef", obs_wr_addr, obs_wr_data[63:32]);
        end
        total++;
        if (obs_rd_addr !== 28'hC || obs_rd_cycles !== 6 || obs_wr_cycles !== 6 || obs_busy !== 14) begin
            bad++;
            $display("[TB] FAIL conflict_timing: got addr=%h rd=%0d wr=%0d busy=%0d required 000000c/6/6/14", obs_rd_addr, obs_rd_cycles, obs_wr_cycles, obs_busy);
        end
        total++;
        if (mem_blocks[4][63:32] !== 32'hDEAD_12EF) begin bad++; $display("[TB] FAIL memory_after_writeback: got %h required dead12ef", mem_blocks[4][63:32]); end
    endtask

    task automatic test_random();
        logic [2:0] load_ops [5];
        load_ops[0] = 3'b000;
        load_ops[1] = 3'b001;
        load_ops[2] = 3'b010;
        load_ops[3] = 3'b100;
        load_ops[4] = 3'b101;
        for (int n = 0; n < 40; n++) begin
            bit st;
            mem_lat = int'($urandom_range(0, 3));
            st = 1'($urandom_range(0, 1));
            if (st) begin
                run_access(1'b1, 3'($urandom_range(0, 2)), 32'($urandom_range(0, 1023)), $urandom);
            end else begin
                run_access(1'b0, load_ops[$urandom_range(0, 4)], 32'($urandom_range(0, 1023)), 32'd0);
            end
        end
    endtask

    task automatic test_store_priority();
        logic [31:0] a;
        logic [31:0] d;
        mem_lat = 0;
        a = 32'($urandom_range(0, 1023)) & ~32'd3;
        d = $urandom;
        run_access(1'b0, 3'b010, a, 32'd0);
        ADDRESS = a;
        WRITE_DATA = d;
        READ_EN = 4'b1010;
        WRITE_EN = 3'b110;
        @(negedge CLK);
        total++;
        if (BUSY_WAIT !== 1'b0 || READ_DATA !== 32'd0) begin
            bad++;
            $display("[TB] FAIL both_set: got busy=%b data=%h required 0/00000000", BUSY_WAIT, READ_DATA);
        end
        @(posedge CLK);
        #1;
        READ_EN = 4'd0;
        WRITE_EN = 3'd0;
        ref_store(2'b10, a, d);
        ref_dirty[int'(a[6:4])] = 1'b1;
        run_access(1'b0, 3'b010, a, 32'd0);
        total++;
        if (obs_rdata !== d) begin bad++; $display("[TB] FAIL store_priority_readback: got %h required %h", obs_rdata, d); end
    endtask

    task automatic test_reset_mid_miss();
        bit seen;
        seen = 1'b0;
        mem_lat = 5;
        ADDRESS = 32'h200;
        READ_EN = 4'b1010;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (MEM_READ === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || BUSY_WAIT !== 1'b1) begin bad++; $display("[TB] FAIL mid_miss_allocate: got seen=%b busy=%b required 1/1", seen, BUSY_WAIT); end
        #2;
        RESET = 1'b0;
        #1;
        total++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || BUSY_WAIT !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_miss_reset_drop: got rd=%b wr=%b busy=%b required 0/0/0", MEM_READ, MEM_WRITE, BUSY_WAIT);
        end
        total++;
        if (MEM_ADDRESS !== 28'd0 || READ_DATA !== 32'd0) begin bad++; $display("[TB] FAIL mid_miss_reset_bus: got %h/%h required 0/0", MEM_ADDRESS, READ_DATA); end
        @(posedge CLK);
        #1;
        total++;
        if (BUSY_WAIT !== 1'b0) begin bad++; $display("[TB] FAIL busy_in_reset: got %b required 0", BUSY_WAIT); end
        READ_EN = 4'd0;
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        sync_ref_from_mem();
        run_access(1'b0, 3'b010, 32'hC0, 32'd0);
        total++;
        if (obs_busy !== 8) begin bad++; $display("[TB] FAIL miss_after_reset: got %0d stall cycles required 8", obs_busy); end
    endtask

    initial begin
        #2;
        RESET = 1'b0;
        test_reset();
        test_fill();
        test_extend();
        test_store_hit();
        test_conflict();
        test_random();
        test_store_priority();
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
